// File: rtl/tt_um_serial_sub.sv
// tt_um_serial_sub: bit-serial 8-bit subtractor tile (A - B, LSB first).
// Operands are loaded over ui_in, start launches an 8-cycle serial pass, and
// the difference lands in uo_out with busy/done/borrow/valid on uio_out.
// Optional build macro TT_SUB_SATURATE_EN: clamp the result to 0x00 on borrow.
module tt_um_serial_sub (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t     state, state_nx;
  logic [7:0] a_reg, b_reg;
  logic [7:0] sa, sb;
  logic       bor;
  logic [2:0] cnt;
  logic [7:0] res;
  logic       borrow_q, valid_q;

  logic load_a, load_b, start;
  assign load_a = uio_in[0];
  assign load_b = uio_in[1];
  assign start  = uio_in[2];

  // ena and the spare control bits carry no function in this tile
  logic unused_ok;
  assign unused_ok = &{ena, uio_in[7:3], 1'b0};

  // one full-subtractor bit per cycle
  logic       d, bor_nx;
  logic [7:0] diff_fin;
  logic [7:0] res_fin;
  always_comb begin
    d        = sa[0] ^ sb[0] ^ bor;
    bor_nx   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bor);
    diff_fin = {d, sa[7:1]};
`ifdef TT_SUB_SATURATE_EN
    res_fin  = bor_nx ? 8'h00 : diff_fin;
`else
    res_fin  = diff_fin;
`endif
  end

  // next-state: start only honoured in IDLE, DONE lasts one cycle
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (cnt == 3'd7) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // holding registers: writable only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= 8'h00;
      b_reg <= 8'h00;
    end else if (state == S_IDLE) begin
      if (load_a) a_reg <= ui_in;
      if (load_b) b_reg <= ui_in;
    end
  end

  // serial datapath; start captures pre-edge holding values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= 8'h00;
      sb  <= 8'h00;
      bor <= 1'b0;
      cnt <= 3'd0;
    end else if (state == S_IDLE && start) begin
      sa  <= a_reg;
      sb  <= b_reg;
      bor <= 1'b0;
      cnt <= 3'd0;
    end else if (state == S_RUN) begin
      sa  <= diff_fin;
      sb  <= {1'b0, sb[7:1]};
      bor <= bor_nx;
      cnt <= cnt + 3'd1;
    end
  end

  // result/flag registers: written on the last serial edge, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res      <= 8'h00;
      borrow_q <= 1'b0;
      valid_q  <= 1'b0;
    end else if (state == S_RUN && cnt == 3'd7) begin
      res      <= res_fin;
      borrow_q <= bor_nx;
      valid_q  <= 1'b1;
    end
  end

  assign uo_out  = res;
  assign uio_out = {valid_q, borrow_q, (state == S_DONE), (state == S_RUN), 4'b0000};
  assign uio_oe  = 8'b1111_0000;

endmodule

// File: tb/tb_tt_um_serial_sub.sv
// Randomized bench for tt_um_serial_sub against a plain-arithmetic model.
module tb_tt_um_serial_sub;

  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic       ena, clk, rst_n;

  tt_um_serial_sub dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: holding registers and last published result
  int m_a, m_b, m_res, m_bor, m_vld;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int busy, input int done);
    chk({tag, ".uo_out"}, uo_out, m_res);
    chk({tag, ".busy"},   uio_out[4], busy);
    chk({tag, ".done"},   uio_out[5], done);
    chk({tag, ".borrow"}, uio_out[6], m_bor);
    chk({tag, ".valid"},  uio_out[7], m_vld);
  endtask

  task automatic load(input int sel, input int v);
    ui_in  = v[7:0];
    uio_in = {6'b0, sel[1:0]};
    tick();
    uio_in = 8'h00;
    if (sel[0]) m_a = v;
    if (sel[1]) m_b = v;
  endtask

  // one full operation; optional load on the start edge and junk during RUN
  task automatic run_op(input string tag, input bit junk, input bit lda, input int din);
    int ea, eb, exp_res, exp_bor;
    ea = m_a;
    eb = m_b;
    exp_bor = (ea < eb) ? 1 : 0;
    exp_res = (ea - eb) & 255;
`ifdef TT_SUB_SATURATE_EN
    if (exp_bor == 1) exp_res = 0;
`endif
    ui_in  = din[7:0];
    uio_in = {5'b0, 1'b1, 1'b0, lda};
    tick();                                   // E0
    if (lda) m_a = din;
    uio_in = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      chk({tag, ".busy_run"}, uio_out[4], 1);
      chk({tag, ".done_run"}, uio_out[5], 0);
      if (junk) begin
        ui_in  = 8'($urandom);
        uio_in = 8'($urandom_range(0, 7));
      end
      tick();                                 // E1..E8
    end
    uio_in = 8'h00;
    m_res = exp_res;
    m_bor = exp_bor;
    m_vld = 1;
    chk_out({tag, ".fin"}, 0, 1);
    tick();                                   // E9
    chk_out({tag, ".post"}, 0, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    m_a = 0; m_b = 0; m_res = 0; m_bor = 0; m_vld = 0;
    #2;
    chk_out("reset", 0, 0);
    chk("reset.oe", uio_oe, 8'hF0);
    chk("reset.low", uio_out[3:0], 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // directed cases
    load(1, 200); load(2, 57);  run_op("d200_57", 0, 0, 0);
    load(1, 57);  load(2, 200); run_op("d57_200", 0, 0, 0);
    load(1, 0);   load(2, 1);   run_op("d0_1",    0, 0, 0);
    load(3, 8'hAA);             run_op("dAA_AA",  0, 0, 0);
    load(1, 255); load(2, 0);   run_op("dFF_0",   0, 0, 0);
    chk("oe.run", uio_oe, 8'hF0);

    // loads/start during RUN are ignored; A_reg proven unchanged by a rerun
    load(1, 100); load(2, 30);
    run_op("junk", 1, 0, 0);
    run_op("junk_rerun", 0, 0, 0);

    // same-edge start + load_a
    load(1, 100); load(2, 30);
    run_op("same_edge", 0, 1, 8'h10);
    run_op("same_edge_next", 0, 0, 0);

    // asynchronous reset in the middle of RUN
    load(1, 99); load(2, 7);
    uio_in = 8'h04;
    tick();
    uio_in = 8'h00;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    m_a = 0; m_b = 0; m_res = 0; m_bor = 0; m_vld = 0;
    chk_out("midrst", 0, 0);
    chk("midrst.oe", uio_oe, 8'hF0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("after_rst", 0, 0, 0);

    // randomized operations
    for (int n = 0; n < 40; n++) begin
      int sel;
      sel = $urandom_range(0, 4);
      if (sel == 3) load(3, $urandom_range(0, 255));
      else if (sel == 4) begin
        load(1, $urandom_range(0, 255));
        load(2, $urandom_range(0, 255));
      end else if (sel != 0) load(sel, $urandom_range(0, 255));
      run_op("rand", $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
